// File: rtl/fetch_stage_if.sv
// Fetch stage bundle: instruction-memory request/response channel plus the
// decode-side control inputs and the registered {inst, pc, valid} output.
interface fetch_stage_if;
    // Instruction memory request (fetch -> memory)
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    // Instruction memory response (memory -> fetch)
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    // Pipeline control from decode / execute
    logic        stall_flg;
    logic        redirect_flg;
    logic [31:0] redirect_pc;
    // Registered output to decode
    logic [31:0] output_inst;
    logic [31:0] output_reg_pc;
    logic        output_valid;

    // The fetch stage drives requests and the decode-facing outputs.
    modport master (
        output mem_req_valid,
        input  mem_req_ready,
        output mem_req_addr,
        input  mem_resp_valid,
        input  mem_resp_data,
        input  stall_flg,
        input  redirect_flg,
        input  redirect_pc,
        output output_inst,
        output output_reg_pc,
        output output_valid
    );

    // Memory / pipeline environment side.
    modport slave (
        input  mem_req_valid,
        output mem_req_ready,
        input  mem_req_addr,
        output mem_resp_valid,
        output mem_resp_data,
        output stall_flg,
        output redirect_flg,
        output redirect_pc,
        input  output_inst,
        input  output_reg_pc,
        input  output_valid
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage. Holds the PC, issues one outstanding read at a
// time to instruction memory, buffers returned words in a small FIFO and
// hands one {inst, pc} pair per cycle to decode. A redirect from execute
// flushes everything in flight; a response to a request issued before the
// redirect is swallowed in the DROP state.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master fch
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       req_pc_q, req_pc_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       out_inst_q, out_inst_d;
    logic [31:0]       out_pc_q, out_pc_d;
    logic              out_vld_q, out_vld_d;

    logic [31:0]       fifo_inst_q [DEPTH];
    logic [31:0]       fifo_pc_q   [DEPTH];

    logic              req_valid;
    logic              req_fire;
    logic              push;
    logic              pop;
    logic              fifo_empty;

    // Request/FIFO handshake terms shared by the FSM, the FIFO and the outputs.
    always_comb begin
        fifo_empty = (cnt_q == '0);
        // A slot must be free at issue time so the eventual push never overflows.
        req_valid  = (state_q == S_REQ) && (cnt_q < FULL_CNT) && !fch.redirect_flg;
        req_fire   = req_valid && fch.mem_req_ready;
        // Only a response to a still-wanted request is buffered.
        push       = (state_q == S_WAIT) && fch.mem_resp_valid && !fch.redirect_flg;
        pop        = !fch.redirect_flg && !fch.stall_flg && !fifo_empty;
    end

    // Next state of the fetch FSM, the PC and the captured request PC.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;

        unique case (state_q)
            S_REQ: begin
                if (req_fire) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response landing with the redirect is discarded but still
                // retires the outstanding request.
                if (fch.mem_resp_valid) begin
                    state_d = S_REQ;
                end else if (fch.redirect_flg) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (fch.mem_resp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        if (fch.redirect_flg) begin
            pc_d = fch.redirect_pc & 32'hFFFF_FFFC;
        end else if (req_fire) begin
            pc_d     = pc_q + 32'd4;
            req_pc_d = pc_q;
        end
    end

    // FIFO pointers and occupancy; a redirect empties the buffer.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        if (fch.redirect_flg) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Decode-facing output registers: bubble on redirect or empty, hold on stall.
    always_comb begin
        out_inst_d = out_inst_q;
        out_pc_d   = out_pc_q;
        out_vld_d  = out_vld_q;

        if (fch.redirect_flg) begin
            out_inst_d = NOP_INST;
            out_pc_d   = 32'd0;
            out_vld_d  = 1'b0;
        end else if (!fch.stall_flg) begin
            if (!fifo_empty) begin
                out_inst_d = fifo_inst_q[rd_ptr_q];
                out_pc_d   = fifo_pc_q[rd_ptr_q];
                out_vld_d  = 1'b1;
            end else begin
                out_inst_d = NOP_INST;
                out_pc_d   = 32'd0;
                out_vld_d  = 1'b0;
            end
        end
    end

    // Control and output state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            out_inst_q <= NOP_INST;
            out_pc_q   <= 32'd0;
            out_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            out_inst_q <= out_inst_d;
            out_pc_q   <= out_pc_d;
            out_vld_q  <= out_vld_d;
        end
    end

    // Request PC capture; pure data, meaningful only while a request is in flight.
    always_ff @(posedge clk) begin
        req_pc_q <= req_pc_d;
    end

    // FIFO storage; entries are qualified by the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_inst_q[wr_ptr_q] <= fch.mem_resp_data;
            fifo_pc_q[wr_ptr_q]   <= req_pc_q;
        end
    end

    assign fch.mem_req_valid = req_valid;
    assign fch.mem_req_addr  = pc_q;
    assign fch.output_inst   = out_inst_q;
    assign fch.output_reg_pc = out_pc_q;
    assign fch.output_valid  = out_vld_q;

endmodule
